// File: rtl/fp32_add_arbiter.sv
// fp32_add_arbiter
//   Shares one pipelined FP32 adder among N_REQ requesters. A round-robin
//   arbiter picks one request per cycle. The arbiter records which requester
//   owns each in-flight operation in a tag FIFO. Results come back from the
//   adder in order, and the FIFO head steers each result to the requester
//   that owns it. Both the issue path and the return path are
//   combinational, so the arbiter adds no latency of its own.
//
// Ports
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_req_valid/o_req_ready  per-requester handshake (ready is one-hot or 0)
//   i_req_a/i_req_b          packed operands, requester k in [32k+31:32k]
//   o_add_a/o_add_b          operands sent to the shared adder
//   o_add_valid/i_add_ready  adder input handshake
//   i_add_result/i_add_valid/o_add_ready  adder output handshake
//   o_rsp_valid/i_rsp_ready  per-requester result handshake
//   o_rsp_data               result, shared by all requesters
//   o_busy                   requests pending or operations in flight
//   o_err                    sticky: the adder returned a result with no tag
module fp32_add_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_REQ-1:0]   i_req_valid,
    output logic [N_REQ-1:0]   o_req_ready,
    input  logic [N_REQ*32-1:0] i_req_a,
    input  logic [N_REQ*32-1:0] i_req_b,
    output logic [31:0]        o_add_a,
    output logic [31:0]        o_add_b,
    output logic               o_add_valid,
    input  logic               i_add_ready,
    input  logic [31:0]        i_add_result,
    input  logic               i_add_valid,
    output logic               o_add_ready,
    output logic [N_REQ-1:0]   o_rsp_valid,
    input  logic [N_REQ-1:0]   i_rsp_ready,
    output logic [31:0]        o_rsp_data,
    output logic               o_busy,
    output logic               o_err
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(TAG_DEPTH);

    logic [IW-1:0] rr_ptr;
    logic          lock_vld;
    logic [IW-1:0] lock_idx;
    logic [IW-1:0] search_idx;
    logic [IW-1:0] grant;
    logic          any_req;
    logic          issue;

    logic [IW-1:0] tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   occ;
    logic          full, empty, pop;
    logic [IW-1:0] head;

    assign any_req = |i_req_valid;
    assign full    = (occ == DEPTH_C);
    assign empty   = (occ == '0);
    assign head    = tag_mem[rd_ptr];

    // First valid requester at or after rr_ptr, with wrap-around.
    always_comb begin
        int  idx;
        logic found;
        search_idx = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && i_req_valid[idx]) begin
                found      = 1'b1;
                search_idx = IW'(idx);
            end
        end
    end

    // A stalled grant stays locked so the operands cannot change under the
    // adder. If the locked requester withdraws, normal search takes over.
    assign grant = (lock_vld && i_req_valid[lock_idx]) ? lock_idx : search_idx;

    always_comb begin
        o_add_a = '0;
        o_add_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant == IW'(k)) begin
                o_add_a = i_req_a[32*k +: 32];
                o_add_b = i_req_b[32*k +: 32];
            end
        end
    end

    assign o_add_valid = !i_reset && any_req && !full;
    assign issue       = o_add_valid && i_add_ready;

    always_comb begin
        o_req_ready = '0;
        if (issue) o_req_ready[grant] = 1'b1;
    end

    // Return path: the FIFO head names the owner of the next result.
    always_comb begin
        o_rsp_valid = '0;
        o_add_ready = 1'b0;
        if (!i_reset && !empty) begin
            o_rsp_valid[head] = i_add_valid;
            o_add_ready       = i_rsp_ready[head];
        end
    end

    assign o_rsp_data = i_add_result;
    assign pop        = i_add_valid && o_add_ready;
    assign o_busy     = any_req || (occ != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            o_err    <= 1'b0;
        end else begin
            lock_vld <= o_add_valid && !i_add_ready;
            lock_idx <= grant;
            if (issue) begin
                rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (issue && !pop)      occ <= occ + 1'b1;
            else if (!issue && pop) occ <= occ - 1'b1;
            if (i_add_valid && empty) o_err <= 1'b1;
        end
    end

    // Tag storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (!i_reset && issue) tag_mem[wr_ptr] <= grant;
    end

endmodule

// File: tb/tb_fp32_add_arbiter.sv
module tb_fp32_add_arbiter;
    logic         i_clk = 1'b0;
    logic         i_reset;
    logic [3:0]   i_req_valid;
    logic [3:0]   o_req_ready;
    logic [127:0] i_req_a, i_req_b;
    logic [31:0]  o_add_a, o_add_b;
    logic         o_add_valid, i_add_ready;
    logic [31:0]  i_add_result;
    logic         i_add_valid, o_add_ready;
    logic [3:0]   o_rsp_valid, i_rsp_ready;
    logic [31:0]  o_rsp_data;
    logic         o_busy, o_err;

    int n_chk = 0;
    int n_err = 0;

    fp32_add_arbiter #(.N_REQ(4), .TAG_DEPTH(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_a(i_req_a), .i_req_b(i_req_b),
        .o_add_a(o_add_a), .o_add_b(o_add_b),
        .o_add_valid(o_add_valid), .i_add_ready(i_add_ready),
        .i_add_result(i_add_result), .i_add_valid(i_add_valid),
        .o_add_ready(o_add_ready),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1'b1; i_req_valid = '0; i_add_ready = 1'b0;
        i_add_result = '0; i_add_valid = 1'b0; i_rsp_ready = '0;
        for (int k = 0; k < 4; k++) begin
            i_req_a[32*k +: 32] = 32'h1000_0000 + k;
            i_req_b[32*k +: 32] = 32'h2000_0000 + k;
        end
        step(); step();

        // Outputs held quiet in reset even with activity on the inputs
        i_req_valid = 4'hF; i_add_ready = 1'b1; i_add_valid = 1'b1;
        #1;
        chk("rst_add_valid", {31'd0, o_add_valid}, 0);
        chk("rst_req_ready", {28'd0, o_req_ready}, 0);
        chk("rst_rsp_valid", {28'd0, o_rsp_valid}, 0);
        chk("rst_add_ready", {31'd0, o_add_ready}, 0);
        chk("rst_err", {31'd0, o_err}, 0);
        step();
        i_reset = 1'b0; i_add_valid = 1'b0; i_rsp_ready = 4'hF;

        // Fairness: two rounds of 0,1,2,3 then full, then in-order drain
        for (int r = 0; r < 2; r++) begin
            i_req_valid = 4'hF;
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("fair_gnt", {28'd0, o_req_ready}, 32'(1 << k));
                chk("fair_a", o_add_a, 32'h1000_0000 + k);
                chk("fair_b", o_add_b, 32'h2000_0000 + k);
                step();
            end
            #1;
            chk("fair_full", {31'd0, o_add_valid}, 0);
            chk("fair_busy", {31'd0, o_busy}, 1);
            i_req_valid = '0;
            for (int k = 0; k < 4; k++) begin
                i_add_valid = 1'b1; i_add_result = 32'hAAAA_0000 + k;
                #1;
                chk("fair_rsp", {28'd0, o_rsp_valid}, 32'(1 << k));
                chk("fair_data", o_rsp_data, 32'hAAAA_0000 + k);
                chk("fair_aready", {31'd0, o_add_ready}, 1);
                step();
            end
            i_add_valid = 1'b0;
            #1;
            chk("fair_idle", {31'd0, o_busy}, 0);
        end

        // Routing: req1 1.0+2.0, req3 3.0+1.0
        i_req_a[63:32]  = 32'h3F80_0000; i_req_b[63:32]  = 32'h4000_0000;
        i_req_a[127:96] = 32'h4040_0000; i_req_b[127:96] = 32'h3F80_0000;
        i_req_valid = 4'b0010;
        #1;
        chk("rt_gnt1", {28'd0, o_req_ready}, 32'h2);
        chk("rt_a1", o_add_a, 32'h3F80_0000);
        chk("rt_b1", o_add_b, 32'h4000_0000);
        step();
        i_req_valid = 4'b1000;
        #1;
        chk("rt_gnt3", {28'd0, o_req_ready}, 32'h8);
        chk("rt_a3", o_add_a, 32'h4040_0000);
        chk("rt_b3", o_add_b, 32'h3F80_0000);
        step();
        i_req_valid = '0; i_add_valid = 1'b1; i_add_result = 32'h4040_0000;
        #1;
        chk("rt_rsp1", {28'd0, o_rsp_valid}, 32'h2);
        chk("rt_data1", o_rsp_data, 32'h4040_0000);
        step();
        i_add_result = 32'h4080_0000;
        #1;
        chk("rt_rsp3", {28'd0, o_rsp_valid}, 32'h8);
        chk("rt_data3", o_rsp_data, 32'h4080_0000);
        step();
        i_add_valid = 1'b0;

        // Stall lock: req2 stalled 3 cycles, req0 arrives in cycle 2
        i_add_ready = 1'b0; i_req_valid = 4'b0100;
        #1;
        chk("lk_valid", {31'd0, o_add_valid}, 1);
        chk("lk_noready", {28'd0, o_req_ready}, 0);
        chk("lk_a_c1", o_add_a, 32'h1000_0002);
        step();
        i_req_valid = 4'b0101;
        #1;
        chk("lk_a_c2", o_add_a, 32'h1000_0002);
        chk("lk_b_c2", o_add_b, 32'h2000_0002);
        step();
        #1;
        chk("lk_a_c3", o_add_a, 32'h1000_0002);
        step();
        i_add_ready = 1'b1;
        #1;
        chk("lk_issue2", {28'd0, o_req_ready}, 32'h4);
        step();
        i_req_valid = 4'b0001;
        #1;
        chk("lk_issue0", {28'd0, o_req_ready}, 32'h1);
        step();
        i_req_valid = '0; i_add_valid = 1'b1;
        #1;
        chk("lk_rsp2", {28'd0, o_rsp_valid}, 32'h4);
        step();
        #1;
        chk("lk_rsp0", {28'd0, o_rsp_valid}, 32'h1);
        step();
        i_add_valid = 1'b0;

        // Full: 4 issues with results back-pressured, one pop, one more issue
        i_rsp_ready = '0; i_req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fl_issue", {28'd0, o_req_ready}, 32'h2);
            step();
        end
        #1;
        chk("fl_full", {31'd0, o_add_valid}, 0);
        i_add_valid = 1'b1; i_add_result = 32'h1234_5678;
        #1;
        chk("fl_rsp_bp", {28'd0, o_rsp_valid}, 32'h2);
        chk("fl_aready_bp", {31'd0, o_add_ready}, 0);
        step();
        #1;
        chk("fl_still_full", {31'd0, o_add_valid}, 0);
        i_rsp_ready = 4'b0010;
        #1;
        chk("fl_pop", {31'd0, o_add_ready}, 1);
        step();
        i_add_valid = 1'b0;
        #1;
        chk("fl_one_more", {28'd0, o_req_ready}, 32'h2);
        step();
        #1;
        chk("fl_full_again", {31'd0, o_add_valid}, 0);
        i_req_valid = '0; i_rsp_ready = 4'hF; i_add_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fl_drain", {28'd0, o_rsp_valid}, 32'h2);
            step();
        end
        i_add_valid = 1'b0;

        // Protocol error: result with no tag outstanding
        i_add_valid = 1'b1;
        #1;
        chk("pe_aready", {31'd0, o_add_ready}, 0);
        chk("pe_rsp", {28'd0, o_rsp_valid}, 0);
        chk("pe_err_pre", {31'd0, o_err}, 0);
        step();
        i_add_valid = 1'b0;
        #1;
        chk("pe_err", {31'd0, o_err}, 1);
        step();
        #1;
        chk("pe_sticky", {31'd0, o_err}, 1);

        // Two ops in flight from req1, then reset mid-operation
        i_req_valid = 4'b0010;
        step(); step();
        i_req_valid = '0;
        #1;
        chk("rs_busy", {31'd0, o_busy}, 1);
        i_reset = 1'b1; i_add_valid = 1'b1; i_req_valid = 4'hF;
        #1;
        chk("rs_add_valid", {31'd0, o_add_valid}, 0);
        chk("rs_req_ready", {28'd0, o_req_ready}, 0);
        chk("rs_rsp", {28'd0, o_rsp_valid}, 0);
        chk("rs_aready", {31'd0, o_add_ready}, 0);
        step();
        i_reset = 1'b0; i_add_valid = 1'b0; i_req_valid = '0;
        #1;
        chk("rs_err", {31'd0, o_err}, 0);
        chk("rs_idle", {31'd0, o_busy}, 0);
        i_req_valid = 4'hF;
        #1;
        chk("rs_resume0", {28'd0, o_req_ready}, 32'h1);
        step();
        i_req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
